// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The pipeline side uses the master modport, the hazard unit uses the slave modport.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             if_id_uses_rt;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic             jump;
  logic             branch_taken;
  logic             clear_stats;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
           jump, branch_taken, clear_stats,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           state, stall_count, flush_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
           jump, branch_taken, clear_stats,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use and control hazard controller: drives PC/IF/ID stall and pipeline flushes,
// with a RUN/STALL/FLUSH FSM so bubbles never retrigger, plus saturating statistics.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic     clock,
  input  logic     reset,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_inc, flush_inc;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;

  assign load_use = hz.id_ex_mem_read && (hz.id_ex_rt != 5'd0) &&
                    ((hz.id_ex_rt == hz.if_id_rs) ||
                     (hz.if_id_uses_rt && (hz.id_ex_rt == hz.if_id_rt)));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    state_d      = ST_RUN;

    // The illegal encoding 3 falls into the default arm and behaves exactly like RUN.
    case (state_q)
      ST_STALL: begin
        if (hz.branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
          state_d      = ST_FLUSH;
        end else if (hz.jump) begin
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (hz.branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
          state_d      = ST_FLUSH;
        end
      end
      default: begin
        if (hz.branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
          state_d      = ST_FLUSH;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
          state_d     = ST_STALL;
        end else if (hz.jump) begin
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
          state_d     = ST_FLUSH;
        end
      end
    endcase

    // While reset is held the pipeline must run freely, even with hazards present.
    if (!reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.clear_stats) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.state        = state_q;
  assign hz.stall_count  = stall_cnt_q;
  assign hz.flush_count  = flush_cnt_q;

endmodule
